// File: rtl/exec_control_md.sv
// Execute-stage control: ALU control decode plus an iterative MUL/SDIV/UDIV engine.
// Multi-cycle ops hold in_ready low while the engine runs one step per clock.
module exec_control_md #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [10:0]      opcode,
    input  logic [5:0]       shamt,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [3:0]       alu_control,
    output logic             ctl_valid,
    output logic [WIDTH-1:0] md_result,
    output logic             md_valid,
    output logic             stall
);

    localparam logic [3:0]  ALU_ADD    = 4'b0010;
    localparam logic [3:0]  ALU_PASS_B = 4'b0111;
    localparam logic [3:0]  ALU_LSL    = 4'b1000;
    localparam logic [3:0]  ALU_LSR    = 4'b1001;
    localparam logic [10:0] OPC_MUL    = 11'b10011011000;
    localparam logic [10:0] OPC_DIV    = 11'b10011010110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, x, y;
    logic             is_div, div0, neg;

    logic [3:0]       dec_ctl;
    logic             dec_mul, dec_div, dec_sdiv;
    logic             transfer, start_md, start_sc;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] step_acc, step_x, step_y, fix_res;

    assign in_ready = (state != BUSY);
    assign stall    = ~in_ready;
    assign md_valid = (state == DONE);
    assign transfer = in_valid & in_ready;
    assign start_md = transfer & (dec_mul | dec_div);
    assign start_sc = transfer & ~(dec_mul | dec_div);

    always_comb begin
        dec_ctl  = ALU_ADD;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        dec_sdiv = 1'b0;
        case (alu_op)
            2'b00: dec_ctl = ALU_ADD;
            2'b01: dec_ctl = ALU_PASS_B;
            2'b11: dec_ctl = opcode[0] ? ALU_LSL : ALU_LSR;
            default: begin
                if (opcode == OPC_MUL) begin
                    dec_mul = 1'b1;
                end else if (opcode == OPC_DIV && shamt == 6'h02) begin
                    dec_div  = 1'b1;
                    dec_sdiv = 1'b1;
                end else if (opcode == OPC_DIV && shamt == 6'h03) begin
                    dec_div = 1'b1;
                end else begin
                    dec_ctl = {1'b0, opcode[9], opcode[3], opcode[8]};
                end
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_md) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = start_md ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divide: acc is the partial remainder, x shifts the dividend out and the
    // quotient in, y is the divisor. Multiply: acc accumulates, x << and y >>.
    always_comb begin
        r_sh     = {acc, x[WIDTH-1]};
        step_acc = acc;
        step_x   = x;
        step_y   = y;
        if (is_div) begin
            if (r_sh >= {1'b0, y}) begin
                step_acc = r_sh[WIDTH-1:0] - y;
                step_x   = {x[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = r_sh[WIDTH-1:0];
                step_x   = {x[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = acc + (y[0] ? x : '0);
            step_x   = x << 1;
            step_y   = y >> 1;
        end
        if (!is_div)   fix_res = step_acc;
        else if (div0) fix_res = '0;
        else if (neg)  fix_res = -step_x;
        else           fix_res = step_x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            alu_control <= ALU_ADD;
            ctl_valid   <= 1'b0;
            md_result   <= '0;
            cnt         <= '0;
            acc         <= '0;
            x           <= '0;
            y           <= '0;
            is_div      <= 1'b0;
            div0        <= 1'b0;
            neg         <= 1'b0;
        end else begin
            state     <= state_nxt;
            ctl_valid <= start_sc;
            if (start_sc) alu_control <= dec_ctl;
            if (start_md) begin
                is_div <= dec_div;
                div0   <= (op_b == '0);
                neg    <= dec_sdiv & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                cnt    <= CNT_W'(WIDTH - 1);
                acc    <= '0;
                // SDIV runs on magnitudes; the sign is restored at the last step
                x      <= (dec_sdiv && op_a[WIDTH-1]) ? -op_a : op_a;
                y      <= (dec_sdiv && op_b[WIDTH-1]) ? -op_b : op_b;
            end else if (state == BUSY) begin
                acc <= step_acc;
                x   <= step_x;
                y   <= step_y;
                cnt <= cnt - 1'b1;
                if (cnt == '0) md_result <= fix_res;
            end
        end
    end

endmodule

// File: tb/tb_exec_control_md.sv
// Directed bench for exec_control_md: 8-bit instance for decode and MUL/DIV
// cases, plus one 64-bit instance for a multiply smoke run.
module tb_exec_control_md;

    localparam logic [3:0]  ADD_C  = 4'b0010;
    localparam logic [3:0]  PASS_C = 4'b0111;
    localparam logic [3:0]  LSL_C  = 4'b1000;
    localparam logic [3:0]  LSR_C  = 4'b1001;
    localparam logic [10:0] MUL_OP = 11'b10011011000;
    localparam logic [10:0] DIV_OP = 11'b10011010110;
    localparam logic [10:0] ADD_OP = 11'b10001011000;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, ctl_valid, md_valid, stall;
    logic [1:0]  alu_op;
    logic [10:0] opcode;
    logic [5:0]  shamt;
    logic [7:0]  op_a, op_b, md_result;
    logic [3:0]  alu_control;

    logic        in_valid64, in_ready64, ctl_valid64, md_valid64, stall64;
    logic [63:0] op_a64, op_b64, md_result64;
    logic [3:0]  alu_control64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_control_md #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .opcode(opcode), .shamt(shamt), .op_a(op_a), .op_b(op_b),
        .alu_control(alu_control), .ctl_valid(ctl_valid), .md_result(md_result),
        .md_valid(md_valid), .stall(stall)
    );

    exec_control_md #(.WIDTH(64), .CNT_W(7)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .alu_op(2'b10), .opcode(MUL_OP), .shamt(6'h00), .op_a(op_a64), .op_b(op_b64),
        .alu_control(alu_control64), .ctl_valid(ctl_valid64), .md_result(md_result64),
        .md_valid(md_valid64), .stall(stall64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one MUL/DIV (accept edge = edge 1) and stops in DONE after edge 9.
    // With poke set, a stray single-cycle request is raised mid-BUSY.
    task automatic run_md(input string tag, input logic [10:0] opc, input logic [5:0] sh,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp,
                          input bit poke);
        logic [3:0] ctl_before;
        ctl_before = alu_control;
        in_valid = 1'b1; alu_op = 2'b10; opcode = opc; shamt = sh; op_a = a; op_b = b;
        tick();
        in_valid = 1'b0; op_a = 8'h00; op_b = 8'h00;
        chk({tag, " ready_low"}, {63'd0, in_ready}, 64'd0);
        chk({tag, " no_ctl"}, {63'd0, ctl_valid}, 64'd0);
        for (int k = 2; k <= 8; k++) begin
            if (poke && k == 4) begin
                in_valid = 1'b1; alu_op = 2'b01;
            end
            tick();
            if (poke && k == 4) begin
                chk({tag, " poke_ctl_valid"}, {63'd0, ctl_valid}, 64'd0);
                chk({tag, " poke_alu_ctl"}, {60'd0, alu_control}, {60'd0, ctl_before});
                in_valid = 1'b0;
            end
            chk({tag, " busy_stall"}, {63'd0, stall}, 64'd1);
            chk({tag, " busy_md_valid"}, {63'd0, md_valid}, 64'd0);
        end
        tick();
        chk({tag, " md_valid"}, {63'd0, md_valid}, 64'd1);
        chk({tag, " ready_done"}, {63'd0, in_ready}, 64'd1);
        chk({tag, " result"}, {56'd0, md_result}, {56'd0, exp});
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; opcode = '0; shamt = '0;
        op_a = '0; op_b = '0; in_valid64 = 1'b0; op_a64 = '0; op_b64 = '0;
        tick(); tick();
        chk("rst in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst ctl_valid", {63'd0, ctl_valid}, 64'd0);
        chk("rst md_valid", {63'd0, md_valid}, 64'd0);
        chk("rst md_result", {56'd0, md_result}, 64'd0);
        chk("rst alu_control", {60'd0, alu_control}, {60'd0, ADD_C});
        reset = 1'b0;
        tick();

        // Single-cycle decode, latency 1
        in_valid = 1'b1; alu_op = 2'b01;
        tick();
        chk("pass_b ctl", {60'd0, alu_control}, {60'd0, PASS_C});
        chk("pass_b valid", {63'd0, ctl_valid}, 64'd1);
        alu_op = 2'b00;
        tick();
        chk("add ctl", {60'd0, alu_control}, {60'd0, ADD_C});
        alu_op = 2'b10; opcode = ADD_OP;
        tick();
        chk("rtype add ctl", {60'd0, alu_control}, 64'h2);
        alu_op = 2'b10; opcode = 11'b10001010000;
        tick();
        chk("rtype and ctl", {60'd0, alu_control}, 64'h0);
        alu_op = 2'b11; opcode = 11'b11010011011;
        tick();
        chk("lsl ctl", {60'd0, alu_control}, {60'd0, LSL_C});
        opcode = 11'b11010011010;
        tick();
        chk("lsr ctl", {60'd0, alu_control}, {60'd0, LSR_C});
        in_valid = 1'b0; alu_op = 2'bxx; opcode = 'x;
        tick();
        chk("idle ctl_valid", {63'd0, ctl_valid}, 64'd0);
        chk("idle hold ctl", {60'd0, alu_control}, {60'd0, LSR_C});
        opcode = '0; alu_op = 2'b00;

        // MUL/DIV with idle gap after each
        run_md("mul", MUL_OP, 6'h00, 8'd13, 8'd11, 8'h8F, 1'b1);
        tick();
        chk("mul back_idle", {63'd0, md_valid}, 64'd0);
        chk("mul held", {56'd0, md_result}, 64'h8F);
        run_md("sdiv -7/2", DIV_OP, 6'h02, 8'hF9, 8'd2, 8'hFD, 1'b0);
        tick();
        run_md("udiv 200/7", DIV_OP, 6'h03, 8'd200, 8'd7, 8'd28, 1'b0);
        tick();
        run_md("sdiv min/-1", DIV_OP, 6'h02, 8'h80, 8'hFF, 8'h80, 1'b0);
        tick();
        run_md("udiv /0", DIV_OP, 6'h03, 8'h55, 8'h00, 8'h00, 1'b0);
        tick();
        run_md("sdiv /0", DIV_OP, 6'h02, 8'h85, 8'h00, 8'h00, 1'b0);
        tick();

        // Back-to-back: second MUL accepted in DONE, then single-cycle op in DONE
        run_md("b2b first", MUL_OP, 6'h00, 8'd13, 8'd11, 8'h8F, 1'b0);
        run_md("b2b second", MUL_OP, 6'h00, 8'd5, 8'd7, 8'h23, 1'b0);
        in_valid = 1'b1; alu_op = 2'b01;
        tick();
        in_valid = 1'b0;
        chk("done sc ctl_valid", {63'd0, ctl_valid}, 64'd1);
        chk("done sc ctl", {60'd0, alu_control}, {60'd0, PASS_C});
        chk("done sc idle", {63'd0, md_valid}, 64'd0);

        // Reset while BUSY with cnt==3 (after edge 5)
        in_valid = 1'b1; alu_op = 2'b10; opcode = MUL_OP; op_a = 8'd9; op_b = 8'd9;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort in_ready", {63'd0, in_ready}, 64'd1);
        chk("abort md_valid", {63'd0, md_valid}, 64'd0);
        chk("abort md_result", {56'd0, md_result}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort quiet", {63'd0, md_valid}, 64'd0);
        end

        // 64-bit smoke multiply: md_valid after edge 65
        in_valid64 = 1'b1; op_a64 = 64'h0000_0001_0000_0001; op_b64 = 64'd3;
        tick();
        in_valid64 = 1'b0;
        chk("w64 ready_low", {63'd0, in_ready64}, 64'd0);
        for (int k = 2; k <= 64; k++) tick();
        chk("w64 not_yet", {63'd0, md_valid64}, 64'd0);
        tick();
        chk("w64 md_valid", {63'd0, md_valid64}, 64'd1);
        chk("w64 result", md_result64, 64'h0000_0003_0000_0003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
